// File: rtl/sourced_rdata_buffer_pkg.sv
// Shared L2 geometry for the SourceD read-data front end, plus the bank-mask
// helper that zeroes the banks a request did not ask for.
package sourced_rdata_buffer_pkg;

  localparam int DATA_W = 64;
  localparam int WAY_W  = 3;
  localparam int SET_W  = 10;
  localparam int MASK_W = 8;
  localparam int SRC_W  = 4;
  localparam int BANK_W = DATA_W / MASK_W;

  function automatic logic [DATA_W-1:0] apply_bank_mask(
    input logic [DATA_W-1:0] data,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] res;
    res = '0;
    for (int b = 0; b < MASK_W; b++) begin
      res[b*BANK_W +: BANK_W] = mask[b] ? data[b*BANK_W +: BANK_W] : {BANK_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/sourced_rdata_buffer_rdata_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so the consumer
// sees flop outputs; an empty FIFO presents all zeros.
module rdata_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain_s;
  logic [W-1:0]     head_q, head_d;
  logic             do_pop_s;

  // Next-state for storage, pointers, occupancy and the registered head.
  always_comb begin
    mem_d    = mem_q;
    do_pop_s = pop_i && (count_q != {CNT_W{1'b0}});
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    remain_s = count_q - CNT_W'(do_pop_s);
    count_d  = remain_s + CNT_W'(push_i);
    // A push into an otherwise-empty FIFO becomes the head directly.
    if (count_d == {CNT_W{1'b0}}) begin
      head_d = '0;
    end else if (remain_s == {CNT_W{1'b0}}) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/sourced_rdata_buffer.sv
// SourceD read front end: credit-gated bank-store reads, one-cycle data
// capture with bank masking, and a small FIFO towards the response path.
module sourced_rdata_buffer
  import sourced_rdata_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [WAY_W-1:0]  req_way_i,
  input  logic [SET_W-1:0]  req_set_i,
  input  logic [MASK_W-1:0] req_mask_i,
  input  logic [SRC_W-1:0]  req_source_i,
  output logic              radr_valid_o,
  input  logic              radr_ready_i,
  output logic [WAY_W-1:0]  radr_way_o,
  output logic [SET_W-1:0]  radr_set_o,
  output logic [MASK_W-1:0] radr_mask_o,
  input  logic [DATA_W-1:0] rdat_data_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic [SRC_W-1:0]  d_source_o,
  output logic [CNT_W-1:0]  count_o
);

  logic                     inflight_q, inflight_d;
  logic [SRC_W-1:0]         src_q, src_d;
  logic [MASK_W-1:0]        mask_q, mask_d;
  logic                     pop_s, credit_s, issue_s;
  logic [CNT_W:0]           occ_s;
  logic [DATA_W+SRC_W-1:0]  push_data_s;
  logic [DATA_W+SRC_W-1:0]  head_s;

  // Credit: a read issues only if its beat has a slot after this cycle's pop.
  always_comb begin
    pop_s        = d_valid_o & d_ready_i;
    occ_s        = {1'b0, count_o} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop_s);
    credit_s     = (occ_s < (CNT_W+1)'(DEPTH)) & ~rst;
    req_ready_o  = radr_ready_i & credit_s;
    radr_valid_o = req_valid_i & credit_s;
    issue_s      = req_valid_i & req_ready_o;
    inflight_d   = issue_s;
    if (issue_s) begin
      src_d  = req_source_i;
      mask_d = req_mask_i;
    end else begin
      src_d  = src_q;
      mask_d = mask_q;
    end
    push_data_s = {apply_bank_mask(rdat_data_i, mask_q), src_q};
  end

  // Sideband of the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      src_q      <= '0;
      mask_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      src_q      <= src_d;
      mask_q     <= mask_d;
    end
  end

  rdata_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + SRC_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_o)
  );

  assign radr_way_o  = req_way_i;
  assign radr_set_o  = req_set_i;
  assign radr_mask_o = req_mask_i;
  assign d_valid_o   = (count_o != {CNT_W{1'b0}});
  assign d_data_o    = head_s[DATA_W+SRC_W-1:SRC_W];
  assign d_source_o  = head_s[SRC_W-1:0];

endmodule

// File: tb/tb_sourced_rdata_buffer.sv
// Directed bench with a scoreboard queue filled by the request driver and
// drained by an independent monitor on the d_* response port.
module tb_sourced_rdata_buffer;
  import sourced_rdata_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid_i, req_ready_o;
  logic [WAY_W-1:0]  req_way_i;
  logic [SET_W-1:0]  req_set_i;
  logic [MASK_W-1:0] req_mask_i;
  logic [SRC_W-1:0]  req_source_i;
  logic              radr_valid_o, radr_ready_i;
  logic [WAY_W-1:0]  radr_way_o;
  logic [SET_W-1:0]  radr_set_o;
  logic [MASK_W-1:0] radr_mask_o;
  logic [DATA_W-1:0] rdat_data_i;
  logic              d_valid_o, d_ready_i;
  logic [DATA_W-1:0] d_data_o;
  logic [SRC_W-1:0]  d_source_o;
  logic [CNT_W-1:0]  count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_issue_cyc = 0;
  int pop_log[$];
  logic [DATA_W+SRC_W-1:0] exp_q[$];
  bit wrap_on = 1'b0;

  sourced_rdata_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_way_i(req_way_i), .req_set_i(req_set_i),
    .req_mask_i(req_mask_i), .req_source_i(req_source_i),
    .radr_valid_o(radr_valid_o), .radr_ready_i(radr_ready_i),
    .radr_way_o(radr_way_o), .radr_set_o(radr_set_o), .radr_mask_o(radr_mask_o),
    .rdat_data_i(rdat_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .d_data_o(d_data_o), .d_source_o(d_source_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] byte_fill(input logic [7:0] b);
    return {8{b}};
  endfunction

  function automatic logic [DATA_W-1:0] model_mask(input logic [DATA_W-1:0] d,
                                                    input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < MASK_W; i++) r[i*8 +: 8] = m[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Drive one request for up to 'budget' cycles; on handshake, queue the
  // expected beat and play the array's read data in the following cycle.
  task automatic issue(input logic [WAY_W-1:0] way, input logic [SET_W-1:0] set,
                       input logic [MASK_W-1:0] mask, input logic [SRC_W-1:0] src,
                       input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp,
                       input int budget, output bit acc);
    acc = 1'b0;
    req_valid_i = 1'b1; req_way_i = way; req_set_i = set;
    req_mask_i = mask; req_source_i = src;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = 1'b1;
        last_issue_cyc = cyc;
        chk("radr_valid", radr_valid_o, 1'b1);
        chk("radr_way", radr_way_o, way);
        chk("radr_set", radr_set_o, set);
        chk("radr_mask", radr_mask_o, mask);
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back({exp, src});
        rdat_data_i = data;
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic issue_must(input logic [WAY_W-1:0] way, input logic [SET_W-1:0] set,
                            input logic [MASK_W-1:0] mask, input logic [SRC_W-1:0] src,
                            input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp);
    bit acc;
    issue(way, set, mask, src, data, exp, 50, acc);
    chk("issue_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: every beat consumed on d_* is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count_bound", (count_o <= CNT_W'(DEPTH)), 1'b1);
      if (d_valid_o && d_ready_i) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h src %0h, none expected", d_data_o, d_source_o);
        end else begin
          logic [DATA_W+SRC_W-1:0] e;
          e = exp_q.pop_front();
          chk("beat_data", d_data_o, e[DATA_W+SRC_W-1:SRC_W]);
          chk("beat_src", d_source_o, e[SRC_W-1:0]);
        end
      end
    end
  end

  initial begin
    bit acc;
    int n_acc;
    rst = 1'b1; req_valid_i = 1'b1; req_way_i = '0; req_set_i = '0;
    req_mask_i = '0; req_source_i = '0; radr_ready_i = 1'b1;
    rdat_data_i = '0; d_ready_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_radr_valid", radr_valid_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_d_valid", d_valid_o, 1'b0);
    chk("rst_count", count_o, 0);
    chk("rst_d_data", d_data_o, 64'h0);
    chk("rst_d_source", d_source_o, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid_i = 1'b0; d_ready_i = 1'b1;

    // Single read: visible exactly two cycles after issue.
    issue_must(3'd1, 10'd3, 8'hFF, 4'd5, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
    @(negedge clk); chk("lat_t1_valid", d_valid_o, 1'b0);
    @(negedge clk); chk("lat_t2_valid", d_valid_o, 1'b1);
    chk("lat_t2_data", d_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("lat_t2_src", d_source_o, 4'd5);
    @(posedge clk); #1;
    drain();

    // Masking: only banks 0 and 2 survive.
    issue_must(3'd2, 10'd7, 8'b0000_0101, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_00FF_00FF);
    drain();

    // Back-to-back: one issue and one beat per cycle.
    pop_log.delete();
    for (int i = 0; i < 8; i++) begin
      int first;
      issue(3'(i), 10'(i + 16), 8'hFF, 4'(i), byte_fill(8'(8'h30 + i)), byte_fill(8'(8'h30 + i)), 1, acc);
      chk("b2b_accept", acc, 1'b1);
      if (i == 0) first = last_issue_cyc;
      if (i == 7) begin
        drain();
        chk("b2b_beats", pop_log.size(), 8);
        for (int k = 0; k < pop_log.size(); k++) chk("b2b_cycle", pop_log[k], first + 2 + k);
      end
    end

    // Backpressure: only DEPTH reads accepted while nothing drains.
    d_ready_i = 1'b0; n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      issue(3'd3, 10'(i), 8'hFF, 4'(10 + i), byte_fill(8'(8'h60 + i)), byte_fill(8'(8'h60 + i)), 1, acc);
      n_acc += int'(acc);
      if (acc == 1'b0) void'(exp_q.size());
    end
    chk("bp_accepted", n_acc, 2);
    req_valid_i = 1'b1;
    @(negedge clk);
    chk("bp_req_ready", req_ready_o, 1'b0);
    chk("bp_count", count_o, 2);
    @(posedge clk); #1;
    d_ready_i = 1'b1; pop_log.delete();
    issue(3'd4, 10'd40, 8'hFF, 4'd14, byte_fill(8'h77), byte_fill(8'h77), 1, acc);
    chk("bp_accept_on_pop", acc, 1'b1);
    chk("bp_first_pop_same_cycle", (pop_log.size() > 0) ? pop_log[0] : -1, last_issue_cyc);
    drain();

    // Wrap with random consumer stalls.
    wrap_on = 1'b1;
    fork
      begin
        logic [MASK_W-1:0] masks [5] = '{8'hFF, 8'h0F, 8'hF0, 8'hAA, 8'h55};
        for (int i = 0; i < 5; i++) begin
          logic [DATA_W-1:0] d;
          d = {byte_fill(8'(8'h80 + i))} ^ 64'h0123_4567_89AB_CDEF;
          issue_must(3'(i), 10'(100 + i), masks[i], 4'(i + 1), d, model_mask(d, masks[i]));
        end
        wrap_on = 1'b0;
      end
      begin
        while (wrap_on) begin
          d_ready_i = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    d_ready_i = 1'b1;
    drain();

    // Reset the cycle after an issue: the in-flight beat must vanish.
    issue_must(3'd5, 10'd200, 8'hFF, 4'd12, byte_fill(8'hEE), byte_fill(8'hEE));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_d_valid", d_valid_o, 1'b0);
      chk("rstmid_count", count_o, 0);
    end

    @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
